// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and counter width live here.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Shift-add multiply, restoring divide, signs fixed at the end.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [MDU_CNT_W-1:0] LAST =
    MDU_CNT_W'(WIDTH - 1);

  mdu_state_e state;
  mdu_op_e    op_q;
  logic [MDU_CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     sh;
  logic [WIDTH-1:0]     a_raw;
  logic                 sa;
  logic                 sb;

  function automatic logic [WIDTH-1:0] cneg(
    input logic [WIDTH-1:0] v,
    input logic             n
  );
    return n ? -v : v;
  endfunction

  logic                 sa_n;
  logic                 sb_n;
  logic [WIDTH-1:0]     ma;
  logic [WIDTH-1:0]     mb;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shl;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]     sh_n;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic                 is_div;
  logic                 div0;
  logic                 div_ok;

  always_comb begin
    sa_n  = ~op[0] & A[WIDTH-1];
    sb_n  = ~op[0] & B[WIDTH-1];
    ma    = cneg(A, sa_n);
    mb    = cneg(B, sb_n);
    is_div = op_q[1];
    // multiply step: add multiplicand to upper half, then shift right
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (sh[0] ? {1'b0, m} : '0);
    // divide step: shift in next dividend bit, trial subtract
    shl   = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    trial = shl - {1'b0, m};
    acc_n = '0;
    sh_n  = '0;
    if (is_div) begin
      acc_n[2*WIDTH-1:WIDTH] = trial[WIDTH] ?
        shl[WIDTH-1:0] : trial[WIDTH-1:0];
      acc_n[WIDTH-1:0] =
        {acc[WIDTH-2:0], ~trial[WIDTH]};
      sh_n = {sh[WIDTH-2:0], 1'b0};
    end else begin
      acc_n = {sum, acc[WIDTH-1:1]};
      sh_n  = {1'b0, sh[WIDTH-1:1]};
    end
    prod   = (sa ^ sb) ? -acc : acc;
    quo    = cneg(acc[WIDTH-1:0], sa ^ sb);
    rem    = cneg(acc[2*WIDTH-1:WIDTH], sa);
    div0   = is_div & ~(|m);
    div_ok = is_div & (|m);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      op_q  <= MDU_MULT;
      cnt   <= '0;
      acc   <= '0;
      m     <= '0;
      sh    <= '0;
      a_raw <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= mdu_op_e'(op);
            sa    <= sa_n;
            sb    <= sb_n;
            a_raw <= A;
            m     <= op[1] ? mb : ma;
            sh    <= op[1] ? ma : mb;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MDU_CALC;
          end else begin
            if (mthi) HI <= A;
            if (mtlo) LO <= A;
          end
        end
        MDU_CALC: begin
          acc <= acc_n;
          sh  <= sh_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= MDU_FIX;
        end
        MDU_FIX: begin
          unique case (1'b1)
            div0: begin
              HI <= a_raw;
              LO <= '1;
            end
            div_ok: begin
              HI <= rem;
              LO <= quo;
            end
            default: {HI, LO} <= prod;
          endcase
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
